// File: rtl/de2_io_pkg.sv
// Shared constants for the DE2 board I/O blocks: switch count, debounce
// timing defaults and the CPU operand word width.
package de2_io_pkg;

    localparam int N_SW_DEFAULT   = 18;
    localparam int DIV_DEFAULT    = 27000;   // 1 ms at 27 MHz
    localparam int STABLE_DEFAULT = 8;
    localparam int WORD_W         = 32;

    // Counter width that can hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch channel: two-flop synchronizer plus a stability counter that
// counts prescaler ticks while the synchronized level disagrees with the
// accepted level. accept is asserted in the cycle the new level qualifies.
module debounce_bit
    import de2_io_pkg::*;
#(
    parameter int STABLE = STABLE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    input  logic level,
    output logic sync,
    output logic accept
);

    localparam int CW = cnt_width(STABLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    logic          meta;
    logic [CW-1:0] cnt;
    logic          differ;

    assign differ = (sync != level);
    assign accept = tick && differ && (cnt == CNT_LAST);

    // Bring the asynchronous board level into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Count ticks of sustained disagreement; any agreement drops the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!differ) begin
            cnt <= '0;
        end else if (tick) begin
            if (cnt == CNT_LAST) cnt <= '0;
            else                 cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the board slide switches. A shared prescaler paces all channels;
// each channel accepts a new level after STABLE consecutive ticks of
// disagreement. Outputs are registered so the change pulse and mask line up
// with the first cycle sw_out shows the new value.
module switch_debouncer
    import de2_io_pkg::*;
#(
    parameter int N_SW   = N_SW_DEFAULT,
    parameter int DIV    = DIV_DEFAULT,
    parameter int STABLE = STABLE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SW-1:0]   sw_raw,
    output logic [N_SW-1:0]   sw_out,
    output logic [WORD_W-1:0] sw_word,
    output logic              changed,
    output logic [N_SW-1:0]   changed_mask
);

    localparam int DW = cnt_width(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [N_SW-1:0] sync;
    logic [N_SW-1:0] accept;

    assign tick    = (div_cnt == DIV_LAST);
    assign sw_word = {{(WORD_W - N_SW){1'b0}}, sw_out};

    // Free-running prescaler, 0..DIV-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DW'(1);
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_bit
        debounce_bit #(
            .STABLE (STABLE)
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .raw    (sw_raw[i]),
            .tick   (tick),
            .level  (sw_out[i]),
            .sync   (sync[i]),
            .accept (accept[i])
        );
    end

    // Load every qualifying bit together and flag exactly those bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_out       <= '0;
            changed_mask <= '0;
            changed      <= 1'b0;
        end else begin
            sw_out       <= (sw_out & ~accept) | (sync & accept);
            changed_mask <= accept;
            changed      <= |accept;
        end
    end

endmodule
